calc_seq_alu: RTL and testbench
===============================

Name: calc_seq_alu

Overview:
- Multi-cycle arithmetic stage for the four-function calculator.
- Takes two unsigned operands and a 2-bit operation select: 00 add, 01 subtract, 10 multiply, 11 divide.
- Produces the result plus the product-overflow and quotient-overflow flags consumed by the decimal-point/overflow display logic directly downstream.
- Multiply is shift-add and divide is restoring; both iterate over W cycles, and a start/busy/done handshake frames each operation.

Parameters:
- W, 8, operand width in bits.
- DISP_MAX, 9999, largest result the decimal display can show; a product above this is an overflow.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only when not busy.
- select  input  2  operation code; latched at start.
- a  input  W  operand A / dividend / multiplicand; latched at start.
- b  input  W  operand B / divisor / multiplier; latched at start.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse when result and flags become valid.
- result  output  2W  sum, |difference|, product or quotient, zero-extended.
- neg  output  1  subtract only: set when a < b.
- product_ofl  output  1  multiply only: set when product > DISP_MAX.
- quotient_ofl  output  1  divide only: set when b == 0.

Behaviour:
- Reset (async, reset_n low): state IDLE; busy, done, neg, product_ofl and quotient_ofl = 0; result = 0; counter and datapath registers = 0. Reset mid-operation aborts it and emits no done.
- States:
  - IDLE: start=1 at edge k latches a, b and select, clears all flags, then goes to CALC (busy=1 from k).
  - CALC, add/sub/div-by-zero: one cycle, then DONE.
  - CALC, multiply/divide: W cycles with a counter running 0..W-1, then DONE.
  - DONE: done=1 and busy=0 for one cycle, then IDLE. A start sampled in DONE is accepted exactly as in IDLE.
- Latency (start edge to done high): add, sub, div-by-zero = 2 edges; multiply, divide = W+1 edges.
- Add: result = a + b, a (W+1)-bit value zero-extended; neither overflow flag is set.
- Subtract: result = |a - b|; neg = (a < b).
- Multiply:
  - Each cycle, if the multiplier LSB is 1, add the multiplicand shifted into the upper half; then shift right.
  - Exact 2W-bit product.
  - product_ofl = (product > DISP_MAX), evaluated on the final value.
- Divide:
  - Restoring division, one quotient bit per cycle, MSB first.
  - result = a / b (truncating).
  - b == 0: result = 0, quotient_ofl = 1, CALC lasts one cycle.
- Hold: result and flags hold from done until the next accepted start, which clears them on its accept edge.
- start while busy: ignored; there is no queueing.
- select, a and b changes during busy: no effect.
- Flags belonging to other operations are always 0.

Optional Feature:
- CALC_REM_EN defined: adds output port remainder, width W.
  - Divide: a % b, valid with done.
  - b == 0: remainder = a.
  - Other operations: 0.
  - Reset value 0; holds like result.
- CALC_REM_EN undefined: no port and no remainder register.
- Quotient and timing are identical either way.

Decomposition:
- Shared package calc_pkg holds:
  - Op-code constants OP_ADD=2'b00, OP_SUB=2'b01, OP_MUL=2'b10, OP_DIV=2'b11.
  - State encoding IDLE/CALC/DONE.
  - DISP_MAX default.
- The downstream overflow/decimal-point logic imports the same op-codes.
- One natural sub-module: calc_iter_core, the shared W-cycle shift register and adder/subtractor used by both multiply and divide. The FSM and flag logic stay in calc_seq_alu.

Test Plan:
- W=8, add 200+100 -> done 2 edges after start; result 300; neg, product_ofl, quotient_ofl = 0.
- Subtract 5-9 -> result 4, neg 1. Subtract 9-5 -> result 4, neg 0.
- Multiply 99*99 -> done at 9 edges; result 9801, product_ofl 0. Multiply 255*255 -> result 65025, product_ofl 1.
- Divide 200/7 -> result 28 (remainder 4 with CALC_REM_EN). Divide 17/0 -> done at 2 edges; result 0, quotient_ofl 1.
- start pulses mid-multiply ignored, only one done. Back-to-back start in the DONE cycle accepted, with flags cleared.
- reset_n low at cycle 4 of a multiply -> all outputs 0 immediately, no done. A later multiply 12*12 -> 144.

Source files
------------

// File: rtl/calc_pkg.sv
// calc_pkg: shared definitions for the calculator arithmetic stage and the
// overflow/decimal-point display logic downstream of it.
//   - op-code constants (add, subtract, multiply, divide)
//   - state encoding of the arithmetic stage FSM
//   - default largest value the decimal display can show
//   - helper deciding whether an operation takes the W-cycle iterative path
package calc_pkg;

    typedef logic [1:0] op_t;

    localparam op_t OP_ADD = 2'b00;
    localparam op_t OP_SUB = 2'b01;
    localparam op_t OP_MUL = 2'b10;
    localparam op_t OP_DIV = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int DISP_MAX_DEFAULT = 9999;

    // Multiply and divide by a non-zero divisor iterate; everything else
    // finishes in a single CALC cycle.
    function automatic logic is_iterative(input op_t op, input logic divisor_zero);
        return (op == OP_MUL) || ((op == OP_DIV) && !divisor_zero);
    endfunction

endpackage

// File: rtl/calc_iter_core.sv
// calc_iter_core: shared shift register and adder/subtractor for the
// shift-add multiplier and the restoring divider.
//   Registers: hi (partial product high half / partial remainder),
//              lo (multiplier shifting out / dividend shifting out, quotient
//              shifting in), opnd (multiplicand / divisor).
// Ports:
//   clk, reset_n  clock, asynchronous active-low reset
//   load          load operands (hi cleared); takes priority over step
//   step          perform one iteration
//   div_mode      1 = restoring divide, 0 = shift-add multiply
//   a, b          operands: multiply loads lo=b, opnd=a; divide lo=a, opnd=b
//   next_val      {hi, lo} as they will be after the current iteration;
//                 after the last multiply step it is the product, after the
//                 last divide step it is {remainder, quotient}
module calc_iter_core #(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           load,
    input  logic           step,
    input  logic           div_mode,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic [2*W-1:0] next_val
);

    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic [W-1:0] opnd;

    logic [W:0]   mul_sum;
    logic [W:0]   shifted;
    logic [W-1:0] trial;
    logic         fits;
    logic [W-1:0] hi_next;
    logic [W-1:0] lo_next;

    always_comb begin
        mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
        // Divide: shift the next dividend bit into the partial remainder and
        // try subtracting the divisor. When it fits, the true difference is
        // below the divisor, so the low W bits of the subtraction are exact.
        shifted = {hi, lo[W-1]};
        fits    = (shifted >= {1'b0, opnd});
        trial   = shifted[W-1:0] - opnd;
        if (div_mode) begin
            hi_next = fits ? trial : shifted[W-1:0];
            lo_next = {lo[W-2:0], fits};
        end else begin
            // Carry of the add becomes the top bit after the right shift.
            hi_next = mul_sum[W:1];
            lo_next = {mul_sum[0], lo[W-1:1]};
        end
        next_val = {hi_next, lo_next};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hi   <= '0;
            lo   <= '0;
            opnd <= '0;
        end else if (load) begin
            hi   <= '0;
            lo   <= div_mode ? a : b;
            opnd <= div_mode ? b : a;
        end else if (step) begin
            hi <= hi_next;
            lo <= lo_next;
        end
    end

endmodule

// File: rtl/calc_seq_alu.sv
// calc_seq_alu: multi-cycle arithmetic stage of the four-function calculator.
// Add/subtract/divide-by-zero finish one cycle after accept; multiply
// (shift-add) and divide (restoring) iterate W cycles in calc_iter_core.
// Optional feature macro: CALC_REM_EN adds the remainder output.
// Handshake: start is accepted on any edge where the stage is not busy
// (IDLE or DONE); busy is high while in CALC; done is a one-cycle pulse in
// DONE when result and flags become valid; they hold until the next accept,
// which clears them.
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   start          operation request
//   select         op code (OP_ADD/OP_SUB/OP_MUL/OP_DIV), latched at accept
//   a, b           operands, latched at accept
//   busy, done     handshake status
//   result         sum, |difference|, product or quotient, zero-extended
//   neg            subtract: a < b
//   product_ofl    multiply: product > DISP_MAX
//   quotient_ofl   divide: b == 0
//   remainder      (CALC_REM_EN only) a % b on divide, a when b == 0
//   state          FSM state for observation (ST_IDLE/ST_CALC/ST_DONE)
module calc_seq_alu
    import calc_pkg::*;
#(
    parameter int W        = 8,
    parameter int DISP_MAX = DISP_MAX_DEFAULT
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           start,
    input  logic [1:0]     select,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*W-1:0] result,
    output logic           neg,
    output logic           product_ofl,
    output logic           quotient_ofl,
`ifdef CALC_REM_EN
    output logic [W-1:0]   remainder,
`endif
    output logic [1:0]     state
);

    localparam int             CW         = $clog2(W);
    localparam logic [CW-1:0]  CNT_LAST   = CW'(W - 1);
    localparam logic [2*W-1:0] DISP_LIMIT = (2*W)'(DISP_MAX);

    logic [CW-1:0]  cnt;
    op_t            op_q;
    logic [W-1:0]   a_q;
    logic [W-1:0]   b_q;
    logic           accept;
    logic           iterative;
    logic           core_div;
    logic [2*W-1:0] core_next;
    logic [W:0]     add_sum;
    logic [W-1:0]   sub_mag;

    assign accept    = start && (state != ST_CALC);
    assign iterative = is_iterative(op_q, (b_q == '0));
    assign busy      = (state == ST_CALC);
    assign done      = (state == ST_DONE);
    assign add_sum   = {1'b0, a_q} + {1'b0, b_q};
    assign sub_mag   = (a_q < b_q) ? (b_q - a_q) : (a_q - b_q);
    // On the accept edge the core loads from the live inputs, so its mode
    // must follow the incoming select rather than the latched one.
    assign core_div  = accept ? (select == OP_DIV) : (op_q == OP_DIV);

    calc_iter_core #(.W(W)) u_core (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (accept),
        .step     ((state == ST_CALC) && iterative),
        .div_mode (core_div),
        .a        (a),
        .b        (b),
        .next_val (core_next)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            op_q         <= OP_ADD;
            a_q          <= '0;
            b_q          <= '0;
            result       <= '0;
            neg          <= 1'b0;
            product_ofl  <= 1'b0;
            quotient_ofl <= 1'b0;
`ifdef CALC_REM_EN
            remainder    <= '0;
`endif
        end else if (accept) begin
            state        <= ST_CALC;
            cnt          <= '0;
            op_q         <= select;
            a_q          <= a;
            b_q          <= b;
            result       <= '0;
            neg          <= 1'b0;
            product_ofl  <= 1'b0;
            quotient_ofl <= 1'b0;
`ifdef CALC_REM_EN
            remainder    <= '0;
`endif
        end else begin
            case (state)
                ST_CALC: begin
                    if (!iterative) begin
                        case (op_q)
                            OP_ADD: result <= {{(W-1){1'b0}}, add_sum};
                            OP_SUB: begin
                                result <= {{W{1'b0}}, sub_mag};
                                neg    <= (a_q < b_q);
                            end
                            default: begin
                                // Divide by zero: quotient stays 0.
                                quotient_ofl <= 1'b1;
`ifdef CALC_REM_EN
                                remainder    <= a_q;
`endif
                            end
                        endcase
                        state <= ST_DONE;
                    end else if (cnt == CNT_LAST) begin
                        // Capture the core's post-step value on the last
                        // iteration edge so DONE shows the finished result.
                        if (op_q == OP_MUL) begin
                            result      <= core_next;
                            product_ofl <= (core_next > DISP_LIMIT);
                        end else begin
                            result <= {{W{1'b0}}, core_next[W-1:0]};
`ifdef CALC_REM_EN
                            remainder <= core_next[2*W-1:W];
`endif
                        end
                        state <= ST_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_calc_seq_alu.sv
// tb_calc_seq_alu: randomized and directed stimulus for calc_seq_alu,
// checked every cycle against a behavioural model of the arithmetic stage.
module tb_calc_seq_alu;
    import calc_pkg::*;

    localparam int W        = 8;
    localparam int DISP_MAX = 9999;

    logic           clk = 1'b0;
    logic           reset_n;
    logic           start;
    logic [1:0]     select;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           busy;
    logic           done;
    logic [2*W-1:0] result;
    logic           neg;
    logic           product_ofl;
    logic           quotient_ofl;
`ifdef CALC_REM_EN
    logic [W-1:0]   remainder;
`endif
    logic [1:0]     state;

    calc_seq_alu #(.W(W), .DISP_MAX(DISP_MAX)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .select       (select),
        .a            (a),
        .b            (b),
        .busy         (busy),
        .done         (done),
        .result       (result),
        .neg          (neg),
        .product_ofl  (product_ofl),
        .quotient_ofl (quotient_ofl),
`ifdef CALC_REM_EN
        .remainder    (remainder),
`endif
        .state        (state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic [2*W-1:0] res;
        logic           neg;
        logic           pofl;
        logic           qofl;
        logic [W-1:0]   rem;
        logic [31:0]    acc;
        logic [31:0]    lat;
    } exp_t;

    exp_t exp_q[$];
    exp_t last;
    int   total = 0;
    int   bad   = 0;
    bit   checking = 0;
    int   last_acc = 0;
    int   last_lat = 0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, act, req, cyc);
        end
    endfunction

    // What the stage must produce for one operation, and how many edges from
    // the accept edge (counted as the first) until done is high.
    function automatic exp_t model(input logic [1:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t e;
        int unsigned xi, yi, p;
        e  = '0;
        xi = x;
        yi = y;
        e.lat = 2;
        case (op)
            OP_ADD: e.res = (2*W)'(xi + yi);
            OP_SUB: begin
                e.res = (xi < yi) ? (2*W)'(yi - xi) : (2*W)'(xi - yi);
                e.neg = (xi < yi);
            end
            OP_MUL: begin
                p      = xi * yi;
                e.res  = (2*W)'(p);
                e.pofl = (p > DISP_MAX);
                e.lat  = W + 1;
            end
            default: begin
                if (yi == 0) begin
                    e.qofl = 1'b1;
                    e.rem  = x;
                end else begin
                    e.res = (2*W)'(xi / yi);
                    e.rem = W'(xi % yi);
                    e.lat = W + 1;
                end
            end
        endcase
        return e;
    endfunction

    // One compare process: every cycle, derive what busy/done/outputs must
    // be from the pending operation (or the last finished one) and check.
    always @(negedge clk) begin
        exp_t want;
        logic w_busy;
        logic w_done;
        if (reset_n && checking) begin
            want   = last;
            w_busy = 1'b0;
            w_done = 1'b0;
            if (exp_q.size() > 0 && cyc >= int'(exp_q[0].acc)) begin
                if (cyc >= int'(exp_q[0].acc + exp_q[0].lat - 1)) begin
                    w_done = 1'b1;
                    want   = exp_q[0];
                end else begin
                    w_busy = 1'b1;
                    want   = '0;
                end
            end
            chk("busy", 32'(busy), 32'(w_busy));
            chk("done", 32'(done), 32'(w_done));
            chk("result", 32'(result), 32'(want.res));
            chk("neg", 32'(neg), 32'(want.neg));
            chk("product_ofl", 32'(product_ofl), 32'(want.pofl));
            chk("quotient_ofl", 32'(quotient_ofl), 32'(want.qofl));
`ifdef CALC_REM_EN
            chk("remainder", 32'(remainder), 32'(want.rem));
`endif
            if (w_done) begin
                last = exp_q[0];
                void'(exp_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Called shortly after a rising edge; the next rising edge accepts.
    task automatic issue(input logic [1:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t e;
        select = op;
        a      = x;
        b      = y;
        start  = 1'b1;
        e      = model(op, x, y);
        e.acc  = 32'(cyc + 1);
        exp_q.push_back(e);
        last_acc = cyc + 1;
        last_lat = int'(e.lat);
        @(posedge clk);
        #1;
        start  = 1'b0;
        select = 2'($urandom_range(0, 3));
        a      = W'($urandom_range(0, 255));
        b      = W'($urandom_range(0, 255));
    endtask

    // Returns in the DONE cycle of the last issued operation.
    task automatic wait_done();
        while (cyc < last_acc + last_lat - 1) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run(input logic [1:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
        wait_done();
        @(posedge clk);
        #1;
        issue(op, x, y);
    endtask

    task automatic check_all_zero(input string nm);
        chk({nm, "_busy"}, 32'(busy), 0);
        chk({nm, "_done"}, 32'(done), 0);
        chk({nm, "_result"}, 32'(result), 0);
        chk({nm, "_neg"}, 32'(neg), 0);
        chk({nm, "_pofl"}, 32'(product_ofl), 0);
        chk({nm, "_qofl"}, 32'(quotient_ofl), 0);
`ifdef CALC_REM_EN
        chk({nm, "_rem"}, 32'(remainder), 0);
`endif
    endtask

    // ---------------- stimulus ----------------
    initial begin
        exp_t m;
        logic [1:0]   op;
        logic [W-1:0] x;
        logic [W-1:0] y;

        last    = '0;
        reset_n = 1'b1;
        start   = 1'b0;
        select  = OP_ADD;
        a       = '0;
        b       = '0;
        #2 reset_n = 1'b0;
        #1 check_all_zero("reset");

        // Pin the model with hand-computed values.
        m = model(OP_ADD, 200, 100);
        chk("pin_add_res", 32'(m.res), 300);
        chk("pin_add_lat", m.lat, 2);
        m = model(OP_SUB, 5, 9);
        chk("pin_sub_res", 32'(m.res), 4);
        chk("pin_sub_neg", 32'(m.neg), 1);
        m = model(OP_MUL, 99, 99);
        chk("pin_mul_res", 32'(m.res), 9801);
        chk("pin_mul_lat", m.lat, 9);
        chk("pin_mul_ofl", 32'(m.pofl), 0);
        m = model(OP_MUL, 255, 255);
        chk("pin_mul2_res", 32'(m.res), 65025);
        chk("pin_mul2_ofl", 32'(m.pofl), 1);
        m = model(OP_DIV, 200, 7);
        chk("pin_div_res", 32'(m.res), 28);
        chk("pin_div_rem", 32'(m.rem), 4);
        m = model(OP_DIV, 17, 0);
        chk("pin_div0_res", 32'(m.res), 0);
        chk("pin_div0_ofl", 32'(m.qofl), 1);
        chk("pin_div0_lat", m.lat, 2);

        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        checking = 1;
        @(posedge clk);
        #1;

        // Directed cases.
        run(OP_ADD, 200, 100);
        run(OP_SUB, 5, 9);
        run(OP_SUB, 9, 5);
        run(OP_MUL, 99, 99);
        run(OP_MUL, 255, 255);
        run(OP_DIV, 200, 7);
        run(OP_DIV, 17, 0);

        // Start pulses while a multiply is running must be ignored.
        run(OP_MUL, 13, 11);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;

        // Back-to-back: new start in the DONE cycle, overflow flag cleared.
        run(OP_MUL, 255, 255);
        wait_done();
        issue(OP_ADD, 1, 2);
        wait_done();
        issue(OP_SUB, 3, 200);

        // Reset during the fourth cycle of a multiply.
        run(OP_MUL, 77, 201);
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b0;
        #1 check_all_zero("midreset");
        exp_q.delete();
        last     = '0;
        last_acc = 0;
        last_lat = 0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk);
        #1;
        run(OP_MUL, 12, 12);

        // Randomized operations with random back-to-back or gapped starts.
        for (int i = 0; i < 60; i++) begin
            op = 2'($urandom_range(0, 3));
            x  = W'($urandom_range(0, 255));
            y  = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom_range(0, 255));
            wait_done();
            if ($urandom_range(0, 1) == 1) begin
                @(posedge clk);
                #1;
            end
            issue(op, x, y);
        end

        wait_done();
        repeat (3) @(posedge clk);
        #1;
        chk("queue_drained", 32'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
